findstr_gen: RTL and testbench

- Byte-stream transmitter that produces the keyword "Welcom" (0x57 0x65 0x6C 0x63 0x6F 0x6D) on a dv/data interface.
- Each byte is qualified by dv.
- It is the source side of the keyword-detector stream and drives the detector in system and bench use.
- A start pulse launches a programmable number of frames, with a programmable idle gap between frames.

---
 rtl/findstr_gen.sv | 138 +++++++++++++
 tb/tb_findstr_gen.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/findstr_gen.sv
// Keyword frame source: sends "Welcom" (or "WWelcom" with FINDSTR_GEN_PREFIX_EN) reps times, gap idle cycles apart.
// All outputs registered; first byte the cycle after start, done the cycle after the last byte.
module findstr_gen #(
  parameter int REP_W = 4,
  parameter int GAP_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [REP_W-1:0] reps,
  input  logic [GAP_W-1:0] gap,
  output logic             dv,
  output logic [7:0]       data,
  output logic             busy,
  output logic             done,
  output logic [REP_W-1:0] sent_cnt
);

  typedef enum logic [1:0] {IDLE, SEND, GAP, FIN} state_t;

`ifdef FINDSTR_GEN_PREFIX_EN
  localparam logic [2:0] LAST = 3'd6;
`else
  localparam logic [2:0] LAST = 3'd5;
`endif

  function automatic logic [7:0] kw(input logic [2:0] i);
    logic [7:0] b;
    b = 8'h00;
`ifdef FINDSTR_GEN_PREFIX_EN
    case (i)
      3'd0:    b = 8'h57;
      3'd1:    b = 8'h57;
      3'd2:    b = 8'h65;
      3'd3:    b = 8'h6C;
      3'd4:    b = 8'h63;
      3'd5:    b = 8'h6F;
      3'd6:    b = 8'h6D;
      default: b = 8'h00;
    endcase
`else
    case (i)
      3'd0:    b = 8'h57;
      3'd1:    b = 8'h65;
      3'd2:    b = 8'h6C;
      3'd3:    b = 8'h63;
      3'd4:    b = 8'h6F;
      3'd5:    b = 8'h6D;
      default: b = 8'h00;
    endcase
`endif
    return b;
  endfunction

  state_t             state;
  logic [2:0]         idx;
  logic [REP_W-1:0]   reps_q;
  logic [GAP_W-1:0]   gap_q;
  logic [GAP_W-1:0]   gap_cnt;
  logic [REP_W-1:0]   sent_nxt;

  assign sent_nxt = sent_cnt + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      idx      <= 3'd0;
      reps_q   <= '0;
      gap_q    <= '0;
      gap_cnt  <= '0;
      dv       <= 1'b0;
      data     <= 8'h00;
      busy     <= 1'b0;
      done     <= 1'b0;
      sent_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            reps_q   <= reps;
            gap_q    <= gap;
            sent_cnt <= '0;
            busy     <= 1'b1;
            idx      <= 3'd0;
            if (reps == '0) begin
              state <= FIN;
              done  <= 1'b1;
            end else begin
              state <= SEND;
              dv    <= 1'b1;
              data  <= kw(3'd0);
            end
          end
        end
        SEND: begin
          if (idx == LAST) begin
            sent_cnt <= sent_nxt;
            idx      <= 3'd0;
            if (sent_nxt == reps_q) begin
              state <= FIN;
              dv    <= 1'b0;
              data  <= 8'h00;
              done  <= 1'b1;
            end else if (gap_q == '0) begin
              // back-to-back frame keeps dv high so the detector never restarts
              data <= kw(3'd0);
            end else begin
              state   <= GAP;
              gap_cnt <= gap_q - 1'b1;
              dv      <= 1'b0;
              data    <= 8'h00;
            end
          end else begin
            idx  <= idx + 3'd1;
            data <= kw(idx + 3'd1);
          end
        end
        GAP: begin
          if (gap_cnt == '0) begin
            state <= SEND;
            idx   <= 3'd0;
            dv    <= 1'b1;
            data  <= kw(3'd0);
          end else begin
            gap_cnt <= gap_cnt - 1'b1;
          end
        end
        FIN: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_findstr_gen.sv
// Bench for findstr_gen: directed and random runs against a per-cycle expected-stream model.
module tb_findstr_gen;

  logic       clk = 1'b0;
  logic       rst, start;
  logic [3:0] reps, gap;
  logic       dv, busy, done;
  logic [7:0] data;
  logic [3:0] sent_cnt;

  findstr_gen #(.REP_W(4), .GAP_W(4)) dut (
    .clk(clk), .rst(rst), .start(start), .reps(reps), .gap(gap),
    .dv(dv), .data(data), .busy(busy), .done(done), .sent_cnt(sent_cnt)
  );

  always #5 clk = ~clk;

`ifdef FINDSTR_GEN_PREFIX_EN
  localparam int FL = 7;
  logic [7:0] word [0:6] = '{8'h57, 8'h57, 8'h65, 8'h6C, 8'h63, 8'h6F, 8'h6D};
`else
  localparam int FL = 6;
  logic [7:0] word [0:5] = '{8'h57, 8'h65, 8'h6C, 8'h63, 8'h6F, 8'h6D};
`endif

  typedef struct packed {
    logic       dv;
    logic [7:0] data;
    logic       busy;
    logic       done;
    logic [3:0] sent;
  } exp_t;

  exp_t expq[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string ctx, input exp_t e);
    chk({ctx, ".dv"},   {7'd0, dv},       {7'd0, e.dv});
    chk({ctx, ".data"}, data,             e.data);
    chk({ctx, ".busy"}, {7'd0, busy},     {7'd0, e.busy});
    chk({ctx, ".done"}, {7'd0, done},     {7'd0, e.done});
    chk({ctx, ".sent"}, {4'd0, sent_cnt}, {4'd0, e.sent});
  endtask

  // Expected output for each cycle after start, straight from the frame/gap rules.
  task automatic build(input int r, input int g);
    int s;
    expq.delete();
    s = 0;
    for (int f = 0; f < r; f++) begin
      for (int b = 0; b < FL; b++) expq.push_back('{1'b1, word[b], 1'b1, 1'b0, 4'(s)});
      s++;
      if (f < r - 1)
        for (int k = 0; k < g; k++) expq.push_back('{1'b0, 8'h00, 1'b1, 1'b0, 4'(s)});
    end
    expq.push_back('{1'b0, 8'h00, 1'b1, 1'b1, 4'(s)});
  endtask

  task automatic run(input string name, input int r, input int g, input bit disturb);
    exp_t idle;
    start = 1'b1; reps = 4'(r); gap = 4'(g);
    build(r, g);
    tick();
    for (int k = 0; k < expq.size(); k++) begin
      chk_all($sformatf("%s.c%0d", name, k + 1), expq[k]);
      if (disturb) begin
        start = 1'($urandom_range(0, 1));
        reps  = 4'($urandom);
        gap   = 4'($urandom);
      end else begin
        start = 1'b0;
      end
      tick();
    end
    idle = '{1'b0, 8'h00, 1'b0, 1'b0, 4'(r)};
    chk_all({name, ".idle"}, idle);
    start = 1'b0;
    tick();
  endtask

  initial begin
    exp_t zero;
    int r, g;
    zero  = '{1'b0, 8'h00, 1'b0, 1'b0, 4'd0};
    rst   = 1'b1; start = 1'b0; reps = 4'd0; gap = 4'd0;
    tick(); tick();
    chk_all("reset", zero);
    rst = 1'b0;
    tick();
    chk_all("idle0", zero);

    run("r1g0", 1, 0, 1'b0);
    run("r3g2", 3, 2, 1'b0);
    run("r0",   0, 5, 1'b0);
    run("r2g0_dist", 2, 0, 1'b1);

    // reset during the third byte of frame 2, with start also raised
    start = 1'b1; reps = 4'd4; gap = 4'd1;
    build(4, 1);
    tick();
    for (int k = 0; k < FL + 4; k++) begin
      chk_all($sformatf("rst_run.c%0d", k + 1), expq[k]);
      start = 1'b0;
      if (k == FL + 3) begin
        rst   = 1'b1;
        start = 1'b1;
      end
      tick();
    end
    chk_all("rst_abort", zero);
    rst = 1'b0; start = 1'b0;
    tick();
    chk_all("rst_idle", zero);
    run("after_rst", 4, 1, 1'b0);

    for (int i = 0; i < 8; i++) begin
      r = $urandom_range(0, 5);
      g = $urandom_range(0, 3);
      run($sformatf("rnd%0d_r%0dg%0d", i, r, g), r, g, 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
